// File: rtl/tns_rx_monitor_21.sv
// Receive-side monitor for the 21-TSV TNS link: capture, decode, transition-rule check, error counting.
// Optional range check on the decoded value is built when TNS_RX_RANGE_CHK_EN is defined.

// Stateless TSV-word decoder: each 3-bit group is one base-7 digit, group 0 least significant.
// Codes 3'b011 and 3'b100 both carry digit 3; the encoder picks whichever obeys the transition rule.
module TNS_dec_21 (
    input  logic [20:0] tsv_i,
    output logic [19:0] value_o
);
    logic [2:0] grp;
    logic [2:0] digit;

    always_comb begin
        value_o = '0;
        grp     = '0;
        digit   = '0;
        for (int j = 6; j >= 0; j--) begin
            grp     = tsv_i[3*j +: 3];
            digit   = grp - {2'b00, grp[2]};
            value_o = value_o * 20'd7 + {17'b0, digit};
        end
    end
endmodule

module tns_rx_monitor_21 #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [20:0]      tsv_in,
    input  logic             tsv_valid,
    input  logic             clear_cnt,
    output logic [19:0]      data_out,
    output logic             data_valid,
    output logic [6:0]       grp_err,
    output logic             range_err,
    output logic             word_err,
    output logic [CNT_W-1:0] err_count
);
    logic [20:0]      tsv_q;
    logic             vld_q;
    logic [6:0]       rbit_q, rbit_d;
    logic [19:0]      data_out_q, decoded_d;
    logic             data_valid_q;
    logic [6:0]       grp_err_q, grp_err_d;
    logic             range_err_q, range_err_d;
    logic             word_err_q, word_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    TNS_dec_21 u_dec (
        .tsv_i   (tsv_q),
        .value_o (decoded_d)
    );

    // A group violates the rule when its code moves against the previous word's group MSB.
    always_comb begin
        grp_err_d = '0;
        rbit_d    = '0;
        for (int j = 0; j < 7; j++) begin
            grp_err_d[j] = ((tsv_q[3*j +: 3] == 3'b100) && !rbit_q[j]) ||
                           ((tsv_q[3*j +: 3] == 3'b011) &&  rbit_q[j]);
            rbit_d[j]    = tsv_q[3*j + 2];
        end
    end

`ifdef TNS_RX_RANGE_CHK_EN
    assign range_err_d = (decoded_d >= 20'd823543);
`else
    assign range_err_d = 1'b0;
`endif

    assign word_err_d = (|grp_err_d) | range_err_d;

    // Clear beats a word completing in the same cycle.
    always_comb begin
        err_count_d = err_count_q;
        if (clear_cnt) begin
            err_count_d = '0;
        end else if (vld_q && word_err_d && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tsv_q        <= '0;
            vld_q        <= 1'b0;
            rbit_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            grp_err_q    <= '0;
            range_err_q  <= 1'b0;
            word_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            tsv_q        <= tsv_in;
            vld_q        <= tsv_valid;
            data_valid_q <= vld_q;
            err_count_q  <= err_count_d;
            if (vld_q) begin
                data_out_q  <= decoded_d;
                grp_err_q   <= grp_err_d;
                range_err_q <= range_err_d;
                word_err_q  <= word_err_d;
                rbit_q      <= rbit_d;
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign grp_err    = grp_err_q;
    assign range_err  = range_err_q;
    assign word_err   = word_err_q;
    assign err_count  = err_count_q;
endmodule
